// File: rtl/hack_pkg.sv
// rtl/hack_pkg.sv - shared constants and loader state encoding
// Contents: frame sync byte, ROM address/word widths, loader FSM states.
package hack_pkg;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;
  localparam int         ADDR_W    = 15;
  localparam int         WORD_W    = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEN_HI,
    ST_LEN_LO,
    ST_DATA_HI,
    ST_DATA_LO,
    ST_CHK,
    ST_DONE
  } loader_state_t;

endpackage

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 UART receiver with input synchroniser
// Ports:
//   clk, reset_n  - system clock, asynchronous active-low reset
//   rx            - serial line, idle high, asynchronous to clk
//   data[7:0]     - received byte, valid while valid is high
//   valid         - 1-cycle pulse at the middle of the stop bit
//   frame_err     - pulses with valid when the stop bit sampled low
module uart_rx #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       rx,
  output logic [7:0] data,
  output logic       valid,
  output logic       frame_err
);

  localparam int            CW   = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  rx_state_t     r_state;
  logic [1:0]    r_sync;
  logic          r_rx_d;
  logic [CW-1:0] r_cnt;
  logic [2:0]    r_bit;
  logic [7:0]    r_shift;
  logic          r_valid;
  logic          r_ferr;
  logic          w_rx;

  assign w_rx      = r_sync[1];
  assign data      = r_shift;
  assign valid     = r_valid;
  assign frame_err = r_ferr;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= RX_IDLE;
      r_sync  <= 2'b11;
      r_rx_d  <= 1'b1;
      r_cnt   <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_valid <= 1'b0;
      r_ferr  <= 1'b0;
    end else begin
      r_sync  <= {r_sync[0], rx};
      r_rx_d  <= w_rx;
      r_valid <= 1'b0;
      r_ferr  <= 1'b0;
      case (r_state)
        RX_IDLE: begin
          // Only a real high-to-low edge starts a byte, so a line left low
          // after a bad stop bit cannot retrigger the receiver.
          if (r_rx_d && !w_rx) begin
            r_state <= RX_START;
            r_cnt   <= '0;
          end
        end
        RX_START: begin
          if (r_cnt == HALF) begin
            r_cnt <= '0;
            r_bit <= '0;
            r_state <= w_rx ? RX_IDLE : RX_DATA;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        RX_DATA: begin
          if (r_cnt == FULL) begin
            r_cnt   <= '0;
            r_shift <= {w_rx, r_shift[7:1]};
            if (r_bit == 3'd7) r_state <= RX_STOP;
            else               r_bit   <= r_bit + 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: begin
          if (r_cnt == FULL) begin
            r_cnt   <= '0;
            r_valid <= 1'b1;
            r_ferr  <= !w_rx;
            r_state <= RX_IDLE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: rtl/prog_loader.sv
// rtl/prog_loader.sv - UART program loader for the Hack instruction ROM
// Ports:
//   clk, reset_n        - system clock, asynchronous active-low reset
//   uart_rx             - serial frame input (8N1)
//   rom_we/addr/wdata   - ROM write port, one strobe per instruction word
//   cpu_reset           - holds the CPU in reset until a good image is loaded
//   loading             - frame in progress
//   loaded, error       - sticky load result flags
module prog_loader
  import hack_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434,
  parameter int TIMEOUT_CLKS = 5_000_000
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              uart_rx,
  output logic              rom_we,
  output logic [ADDR_W-1:0] rom_addr,
  output logic [WORD_W-1:0] rom_wdata,
  output logic              cpu_reset,
  output logic              loading,
  output logic              loaded,
  output logic              error
);

  localparam int            TW       = $clog2(TIMEOUT_CLKS + 1);
  localparam logic [TW-1:0] GAP_LAST = TW'(TIMEOUT_CLKS);

  logic [7:0]        w_byte;
  logic              w_valid;
  logic              w_ferr;

  loader_state_t     r_state;
  logic [14:0]       r_len;
  logic [7:0]        r_hi;
  logic [7:0]        r_chk;
  logic [TW-1:0]     r_gap;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [WORD_W-1:0] r_wdata;
  logic              r_cpu_reset;
  logic              r_loading;
  logic              r_loaded;
  logic              r_error;

  uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .clk       (clk),
    .reset_n   (reset_n),
    .rx        (uart_rx),
    .data      (w_byte),
    .valid     (w_valid),
    .frame_err (w_ferr)
  );

  assign rom_we    = r_we;
  assign rom_addr  = r_addr;
  assign rom_wdata = r_wdata;
  assign cpu_reset = r_cpu_reset;
  assign loading   = r_loading;
  assign loaded    = r_loaded;
  assign error     = r_error;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= ST_IDLE;
      r_len       <= '0;
      r_hi        <= '0;
      r_chk       <= '0;
      r_gap       <= '0;
      r_we        <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_cpu_reset <= 1'b1;
      r_loading   <= 1'b0;
      r_loaded    <= 1'b0;
      r_error     <= 1'b0;
    end else begin
      r_we <= 1'b0;
      // Address advances the cycle after the write strobe; 15-bit wrap is intended.
      if (r_we) r_addr <= r_addr + 1'b1;

      case (r_state)
        ST_IDLE: begin
          r_gap <= '0;
          if (w_valid && !w_ferr && (w_byte == SYNC_BYTE)) begin
            r_state     <= ST_LEN_HI;
            r_cpu_reset <= 1'b1;
            r_loading   <= 1'b1;
            r_error     <= 1'b0;
            r_addr      <= '0;
            r_chk       <= '0;
          end
        end
        ST_DONE: r_state <= ST_IDLE;
        default: begin
          if ((w_valid && w_ferr) || (!w_valid && (r_gap == GAP_LAST))) begin
            // Framing error or byte-gap timeout: abandon the image.
            r_error   <= 1'b1;
            r_loading <= 1'b0;
            r_state   <= ST_IDLE;
          end else if (!w_valid) begin
            r_gap <= r_gap + 1'b1;
          end else begin
            r_gap <= '0;
            case (r_state)
              ST_LEN_HI: begin
                r_len[14:8] <= w_byte[6:0];
                r_state     <= ST_LEN_LO;
              end
              ST_LEN_LO: begin
                r_len[7:0] <= w_byte;
                r_state    <= ({r_len[14:8], w_byte} == 15'd0) ? ST_CHK : ST_DATA_HI;
              end
              ST_DATA_HI: begin
                r_hi    <= w_byte;
                r_chk   <= r_chk ^ w_byte;
                r_state <= ST_DATA_LO;
              end
              ST_DATA_LO: begin
                r_wdata <= {r_hi, w_byte};
                r_we    <= 1'b1;
                r_chk   <= r_chk ^ w_byte;
                r_len   <= r_len - 1'b1;
                r_state <= (r_len == 15'd1) ? ST_CHK : ST_DATA_HI;
              end
              ST_CHK: begin
                r_loading <= 1'b0;
                if (w_byte == r_chk) begin
                  r_loaded    <= 1'b1;
                  r_cpu_reset <= 1'b0;
                  r_state     <= ST_DONE;
                end else begin
                  r_error <= 1'b1;
                  r_state <= ST_IDLE;
                end
              end
              default: r_state <= ST_IDLE;
            endcase
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// tb/tb_prog_loader.sv - self-checking bench for prog_loader
module tb_prog_loader;

  localparam int CPB = 8;
  localparam int TMO = 300;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        uart_rx;
  logic        rom_we;
  logic [14:0] rom_addr;
  logic [15:0] rom_wdata;
  logic        cpu_reset;
  logic        loading;
  logic        loaded;
  logic        error;

  int checks = 0;
  int errors = 0;

  logic [7:0]  sb[$];
  bit          sbad[$];
  logic [14:0] wa_q[$];
  logic [15:0] wd_q[$];
  logic [14:0] ea_q[$];
  logic [15:0] ed_q[$];
  logic [14:0] exp_addr;
  logic        exp_loaded, exp_error, exp_cpu_reset;
  bit          exp_trunc;

  always #5 clk = ~clk;

  prog_loader #(.CLKS_PER_BIT(CPB), .TIMEOUT_CLKS(TMO)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .uart_rx   (uart_rx),
    .rom_we    (rom_we),
    .rom_addr  (rom_addr),
    .rom_wdata (rom_wdata),
    .cpu_reset (cpu_reset),
    .loading   (loading),
    .loaded    (loaded),
    .error     (error)
  );

  always @(negedge clk) begin
    if (rom_we === 1'b1) begin
      wa_q.push_back(rom_addr);
      wd_q.push_back(rom_wdata);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, ".rom_we"},    32'(rom_we),    32'd0);
    chk({tag, ".rom_addr"},  32'(rom_addr),  32'd0);
    chk({tag, ".rom_wdata"}, 32'(rom_wdata), 32'd0);
    chk({tag, ".cpu_reset"}, 32'(cpu_reset), 32'd1);
    chk({tag, ".loading"},   32'(loading),   32'd0);
    chk({tag, ".loaded"},    32'(loaded),    32'd0);
    chk({tag, ".error"},     32'(error),     32'd0);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    @(negedge clk) uart_rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int k = 0; k < 8; k++) begin
      uart_rx = b[k];
      repeat (CPB) @(negedge clk);
    end
    uart_rx = stop;
    repeat (CPB) @(negedge clk);
    uart_rx = 1'b1;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic all_good();
    sbad.delete();
    for (int k = 0; k < sb.size(); k++) sbad.push_back(1'b0);
  endtask

  // Reference: walk the byte stream frame by frame. A frame is sync, two
  // length bytes, 2N data bytes and a checksum; any bad byte or end of
  // stream inside a frame aborts it.
  task automatic model();
    int i, k, idx, n;
    logic [7:0] xr;
    i = 0;
    exp_trunc = 0;
    while (i < sb.size()) begin
      if (sbad[i] || sb[i] != 8'hA5) begin
        i++;
      end else begin
        exp_error = 0; exp_cpu_reset = 1; exp_addr = 0; xr = 0; n = 0; k = 1;
        forever begin
          idx = i + k;
          if (idx >= sb.size()) begin exp_error = 1; exp_trunc = 1; i = idx; break; end
          if (sbad[idx]) begin exp_error = 1; i = idx + 1; break; end
          if (k == 2) n = int'({sb[i+1][6:0], sb[idx]});
          if (k >= 3 && k == 3 + 2 * n) begin
            if (sb[idx] == xr) begin exp_loaded = 1; exp_cpu_reset = 0; end
            else exp_error = 1;
            i = idx + 1;
            break;
          end
          if (k >= 3) begin
            xr ^= sb[idx];
            if (k % 2 == 0) begin
              ea_q.push_back(exp_addr);
              ed_q.push_back({sb[idx-1], sb[idx]});
              exp_addr++;
            end
          end
          k++;
        end
      end
    end
  endtask

  task automatic run_stream(input string tag);
    wa_q.delete(); wd_q.delete(); ea_q.delete(); ed_q.delete();
    model();
    for (int k = 0; k < sb.size(); k++) begin
      send_byte(sb[k], !sbad[k]);
      if (k == 1 && sb[0] == 8'hA5 && !sbad[0] && !sbad[1]) begin
        chk({tag, ".mid_loading"},   32'(loading),   32'd1);
        chk({tag, ".mid_cpu_reset"}, 32'(cpu_reset), 32'd1);
      end
    end
    repeat (2 * CPB) @(negedge clk);
    if (exp_trunc) begin
      chk({tag, ".pre_tmo_loading"}, 32'(loading), 32'd1);
      chk({tag, ".pre_tmo_error"},   32'(error),   32'd0);
    end
    repeat (TMO + 4 * CPB) @(negedge clk);
    chk({tag, ".nwrites"}, 32'(wa_q.size()), 32'(ea_q.size()));
    for (int k = 0; k < ea_q.size(); k++) begin
      if (k < wa_q.size()) begin
        chk($sformatf("%s.waddr%0d", tag, k), 32'(wa_q[k]), 32'(ea_q[k]));
        chk($sformatf("%s.wdata%0d", tag, k), 32'(wd_q[k]), 32'(ed_q[k]));
      end
    end
    chk({tag, ".loaded"},    32'(loaded),    32'(exp_loaded));
    chk({tag, ".error"},     32'(error),     32'(exp_error));
    chk({tag, ".cpu_reset"}, 32'(cpu_reset), 32'(exp_cpu_reset));
    chk({tag, ".loading"},   32'(loading),   32'd0);
    chk({tag, ".rom_addr"},  32'(rom_addr),  32'(exp_addr));
    chk({tag, ".rom_we"},    32'(rom_we),    32'd0);
  endtask

  initial begin
    int n, g;
    logic [7:0] v, xr;

    reset_n = 1'b0;
    uart_rx = 1'b1;
    exp_loaded = 0; exp_error = 0; exp_cpu_reset = 1; exp_addr = 0;
    repeat (5) @(negedge clk);
    check_reset_vals("in_reset");
    reset_n = 1'b1;
    repeat (200) @(negedge clk);
    check_reset_vals("idle_after_reset");

    sb = '{8'hA5, 8'h00, 8'h02, 8'h30, 8'h39, 8'hEC, 8'h10, 8'hF4};
    all_good();
    run_stream("bad_chk");

    sb = '{8'hA5, 8'h00, 8'h02, 8'h30, 8'h39, 8'hEC, 8'h10, 8'hF5};
    all_good();
    run_stream("good");

    sb = '{8'h00, 8'hFF, 8'h5A, 8'hA5, 8'h00, 8'h00, 8'h00};
    all_good();
    run_stream("garbage_zero_len");

    sb = '{8'hA5, 8'h00, 8'h02, 8'h30, 8'h39, 8'hEC, 8'h10, 8'hF5};
    all_good();
    sbad[3] = 1'b1;
    run_stream("frame_err");

    sb = '{8'hA5, 8'h00, 8'h02};
    all_good();
    run_stream("timeout");

    sb = '{8'hA5, 8'h00, 8'h01, 8'hA5, 8'hA5, 8'h00};
    all_good();
    run_stream("sync_as_data");

    sb = '{8'hA5, 8'h80, 8'h01, 8'h12, 8'h34, 8'h26};
    all_good();
    run_stream("len_bit15");

    for (int r = 0; r < 6; r++) begin
      sb.delete();
      g = $urandom_range(0, 2);
      for (int k = 0; k < g; k++) begin
        v = 8'($urandom_range(0, 255));
        if (v == 8'hA5) v = 8'h00;
        sb.push_back(v);
      end
      sb.push_back(8'hA5);
      n = $urandom_range(0, 5);
      sb.push_back({1'($urandom_range(0, 1)), 7'd0});
      sb.push_back(8'(n));
      xr = 8'h00;
      for (int k = 0; k < 2 * n; k++) begin
        v = 8'($urandom_range(0, 255));
        xr ^= v;
        sb.push_back(v);
      end
      if ($urandom_range(0, 2) == 0) xr ^= 8'($urandom_range(1, 255));
      sb.push_back(xr);
      all_good();
      run_stream($sformatf("rnd%0d", r));
    end

    // Reset in the middle of the data phase, applied between clock edges.
    send_byte(8'hA5, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h03, 1'b1);
    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b1);
    send_byte(8'h33, 1'b1);
    @(posedge clk);
    #2 reset_n = 1'b0;
    #1 check_reset_vals("mid_data_reset");
    exp_loaded = 0; exp_error = 0; exp_cpu_reset = 1; exp_addr = 0;
    @(negedge clk) reset_n = 1'b1;
    repeat (100) @(negedge clk);
    check_reset_vals("after_mid_reset");

    sb = '{8'hA5, 8'h00, 8'h02, 8'h30, 8'h39, 8'hEC, 8'h10, 8'hF5};
    all_good();
    run_stream("good_after_reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
